aes_inv_cipher_iter: RTL

- Iterative AES-128 decryptor. It is the receive-side counterpart of the unrolled combinational AES-128 encryptor.
- Loads a cipher key once and expands it forward to the last round key (rk10).
- Decrypts each 128-bit block one round per clock, regenerating round keys backwards on the fly.
- Sits behind the link receiver; valid/ready on both sides.

---
 rtl/aes_pkg.sv | 97 +++++++++
 rtl/aes_inv_cipher_iter_if.sv | 26 ++
 rtl/aes_inv_round.sv | 35 +++
 rtl/aes_inv_cipher_iter.sv | 89 ++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, GF(2^8) helpers, S-boxes and key-schedule steps
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;
  localparam int         NK = 4;

  typedef logic [0:127] block_t;

  typedef enum logic [2:0] {IDLE, EXPAND, READY, DEC, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic block_t fwd_step(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[0:31] ^ sub_word(rot_word(k[96:127])) ^ {rc, 24'h0};
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo fwd_step: recover the previous round key from the current one.
  function automatic block_t inv_step(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[96:127] ^ k[64:95];
    w2 = k[64:95] ^ k[32:63];
    w1 = k[32:63] ^ k[0:31];
    w0 = k[0:31] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - key load, ciphertext in and plaintext out handshakes
interface aes_inv_cipher_iter_if;
  import aes_pkg::*;

  logic   key_load;
  block_t key_in;
  logic   key_ready;
  block_t key_last;
  logic   in_valid;
  logic   in_ready;
  block_t state_in;
  logic   out_valid;
  logic   out_ready;
  block_t state_out;

  modport master (
    output key_load, key_in, in_valid, state_in, out_ready,
    input  key_ready, key_last, in_ready, out_valid, state_out
  );

  modport slave (
    input  key_load, key_in, in_valid, state_in, out_ready,
    output key_ready, key_last, in_ready, out_valid, state_out
  );

endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round; last skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  block_t st_in,
  input  block_t rk,
  input  logic   last,
  output block_t st_out
);

  block_t sr;
  block_t ark;
  block_t mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = a;
    return {gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09),
            gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d),
            gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b),
            gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e)};
  endfunction

  // Byte r+4c is row r, column c; row r rotates right by r.
  for (genvar c = 0; c < NK; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*(r+4*c) +: 8] = inv_sbox(st_in[8*(r + 4*((c - r + 4) % 4)) +: 8]);
    end
    assign mixed[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
  end

  assign ark    = sr ^ rk;
  assign st_out = last ? ark : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decryptor, one round per clock with
// round keys regenerated backwards from rk10
module aes_inv_cipher_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_iter_if.slave bus
);

  state_t     state;
  block_t     rk;
  block_t     st;
  block_t     rk_next;
  block_t     rk_prev;
  block_t     round_out;
  logic [3:0] rnd;

  assign rk_next      = fwd_step(rk, rcon(rnd));
  assign rk_prev      = inv_step(rk, rcon(rnd + 4'd1));
  assign bus.in_ready = (state == READY) && !bus.key_load;

  aes_inv_round u_round (
    .st_in  (st),
    .rk     (rk_prev),
    .last   (rnd == 4'd0),
    .st_out (round_out)
  );

  // rk is the expansion register and later the backward-running work key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rk            <= '0;
      st            <= '0;
      rnd           <= '0;
      bus.key_ready <= 1'b0;
      bus.key_last  <= '0;
      bus.out_valid <= 1'b0;
      bus.state_out <= '0;
    end else if (bus.key_load) begin
      state         <= EXPAND;
      rk            <= bus.key_in;
      rnd           <= 4'd1;
      bus.key_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.state_out <= '0;
    end else begin
      case (state)
        EXPAND: begin
          rk  <= rk_next;
          rnd <= rnd + 4'd1;
          if (rnd == NR) begin
            bus.key_last  <= rk_next;
            bus.key_ready <= 1'b1;
            state         <= READY;
          end
        end
        READY: begin
          if (bus.in_valid) begin
            st    <= bus.state_in ^ bus.key_last;
            rk    <= bus.key_last;
            rnd   <= NR - 4'd1;
            state <= DEC;
          end
        end
        DEC: begin
          rk <= rk_prev;
          if (rnd == 4'd0) begin
            bus.state_out <= round_out;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            st  <= round_out;
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= READY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
